// File: rtl/bus_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer slave:
// register offsets (s_addr[5:3] index), FSM encoding and STATUS bit positions.
package bus_timer_pkg;

  localparam logic [2:0] OFF_START    = 3'd0;
  localparam logic [2:0] OFF_CLEAR    = 3'd1;
  localparam logic [2:0] OFF_INTR_EN  = 3'd2;
  localparam logic [2:0] OFF_LOAD     = 3'd3;
  localparam logic [2:0] OFF_PRESCALE = 3'd4;
  localparam logic [2:0] OFF_COUNT    = 3'd5;
  localparam logic [2:0] OFF_STATUS   = 3'd6;
  localparam logic [2:0] OFF_CTRL     = 3'd7;

  localparam int STAT_DONE_BIT = 0;
  localparam int STAT_BUSY_BIT = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Prescale divider: reloads on load or when it wraps, ticks while at zero.
module timer_prescaler #(
  parameter int PRE_W = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [PRE_W-1:0] reload_i,
  output logic             tick_o
);

  logic [PRE_W-1:0] pre_q;
  logic [PRE_W-1:0] pre_d;

  always_comb begin
    pre_d = pre_q;
    if (load_i) begin
      pre_d = reload_i;
    end else if (en_i) begin
      if (pre_q == '0) pre_d = reload_i;
      else             pre_d = pre_q - PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) pre_q <= '0;
    else       pre_q <= pre_d;
  end

  assign tick_o = (pre_q == '0);

endmodule

// File: rtl/bus_timer_slave.sv
// 64-bit countdown timer bus slave: register file, IDLE/RUN/DONE FSM and
// combinational read mux; the prescale divider lives in timer_prescaler.
module bus_timer_slave
  import bus_timer_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 16,
  parameter int PRE_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_sel,
  input  logic              s_wr,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [DATA_W-1:0] s_din,
  output logic [DATA_W-1:0] s_dout,
  output logic              interrupt
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] load_q;
  logic [PRE_W-1:0]  prescale_q;
  logic              intr_en_q;
  logic              auto_reload_q;

  logic [2:0]        reg_sel;
  logic              wr_en, start_req, clear_req, done_w1c, clr;
  logic              pre_load, pre_en, pre_tick;
  logic [DATA_W-1:0] rd_data;
  logic              unused_addr;

  assign reg_sel     = s_addr[5:3];
  assign unused_addr = ^{s_addr[ADDR_W-1:6], s_addr[2:0]};
  assign wr_en       = s_sel & s_wr;
  assign start_req   = wr_en && (reg_sel == OFF_START)  && s_din[0];
  assign clear_req   = wr_en && (reg_sel == OFF_CLEAR)  && s_din[0];
  assign done_w1c    = wr_en && (reg_sel == OFF_STATUS) && s_din[0];
  assign clr         = reset | clear_req;

  timer_prescaler #(.PRE_W(PRE_W)) u_prescaler (
    .clk      (clk),
    .clr_i    (clr),
    .load_i   (pre_load),
    .en_i     (pre_en),
    .reload_i (prescale_q),
    .tick_o   (pre_tick)
  );

  // Expiry is evaluated after the W1C so a coincident expiry keeps done set.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    done_d   = done_q;
    pre_load = 1'b0;
    pre_en   = 1'b0;
    if (done_w1c) done_d = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start_req) begin
          if (load_q != '0) begin
            count_d  = load_q;
            pre_load = 1'b1;
            state_d  = RUN;
          end else begin
            count_d = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        pre_en = 1'b1;
        if (pre_tick && (count_q != '0)) begin
          count_d = count_q - DATA_W'(1);
          if (count_q == DATA_W'(1)) begin
            done_d = 1'b1;
            if (auto_reload_q && (load_q != '0)) count_d = load_q;
            else                                 state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      load_q        <= '0;
      prescale_q    <= '0;
      intr_en_q     <= 1'b0;
      auto_reload_q <= 1'b0;
    end else if (wr_en) begin
      case (reg_sel)
        OFF_INTR_EN:  intr_en_q     <= s_din[0];
        OFF_LOAD:     load_q        <= s_din;
        OFF_PRESCALE: prescale_q    <= s_din[PRE_W-1:0];
        OFF_CTRL:     auto_reload_q <= s_din[0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    if (s_sel && !s_wr) begin
      case (reg_sel)
        OFF_INTR_EN:  rd_data[0] = intr_en_q;
        OFF_LOAD:     rd_data = load_q;
        OFF_PRESCALE: rd_data[PRE_W-1:0] = prescale_q;
        OFF_COUNT:    rd_data = count_q;
        OFF_STATUS: begin
          rd_data[STAT_DONE_BIT] = done_q;
          rd_data[STAT_BUSY_BIT] = (state_q == RUN);
        end
        OFF_CTRL:     rd_data[0] = auto_reload_q;
        default: ;
      endcase
    end
  end

  assign s_dout    = rd_data;
  assign interrupt = done_q & intr_en_q;

endmodule

// File: doc/bus_timer_slave.md
Name: bus_timer_slave

Overview:
- Memory-mapped 64-bit countdown timer acting as a bus slave (responder) on the system bus.
- Sits beside the existing accelerator slaves and is selected by the bus address decoder, e.g. at base 0x7100.
- The bus master programs LOAD and PRESCALE, enables the interrupt and starts the timer.
- On expiry it raises a sticky done flag and, if enabled, `interrupt`. The master then reads COUNT/STATUS and clears done.

Parameters:
- DATA_W, 64, bus data width and COUNT/LOAD width.
- ADDR_W, 16, bus address width.
- PRE_W, 16, prescaler width.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- s_sel  in  1  slave select from the bus decoder.
- s_wr  in  1  1 = write, 0 = read; valid while s_sel=1.
- s_addr  in  ADDR_W  byte address; only s_addr[5:3] is decoded.
- s_din  in  DATA_W  write data.
- s_dout  out  DATA_W  read data.
- interrupt  out  1  done & intr_en.

Behaviour:
- Reset: one clock, synchronous and active-high. All registers go to 0, state=IDLE, s_dout=0, interrupt=0.
- Register map (8-byte stride, s_addr[2:0] ignored; unused bits read as 0):
  - 0x00 START: write-only; bit0=1 issues start.
  - 0x08 CLEAR: write-only; bit0=1 soft clear, identical to reset.
  - 0x10 INTR_EN: R/W, bit0.
  - 0x18 LOAD: R/W, DATA_W bits.
  - 0x20 PRESCALE: R/W, PRE_W bits, zero-extended on read.
  - 0x28 COUNT: read-only, current count.
  - 0x30 STATUS: bit0 done (write 1 to clear), bit1 busy (state==RUN).
  - 0x38 CTRL: R/W, bit0 auto_reload.
- Writes take effect on the rising edge where s_sel=1 and s_wr=1. Reads of write-only registers return 0.
- Reads are combinational: s_dout = selected register when s_sel=1 and s_wr=0, else 0. Data is valid in the same cycle, with zero-wait handshake.
- FSM states are IDLE, RUN and DONE.
- IDLE or DONE + START:
  - LOAD!=0: count<=LOAD, pre<=PRESCALE, go to RUN.
  - LOAD==0: done<=1, count<=0, go to DONE.
- RUN, each cycle:
  - pre!=0: pre<=pre-1.
  - pre==0: pre<=PRESCALE and count<=count-1.
  - When count reaches 0: done<=1. With auto_reload=1, count<=LOAD and the FSM stays in RUN; otherwise it goes to DONE.
  - If LOAD==0 at reload time, the FSM goes to DONE.
- START while in RUN is ignored.
- Timing: if START is sampled at edge E0, done rises at edge E0+LOAD*(PRESCALE+1), with count==0 at the same edge.
- LOAD or PRESCALE written during RUN affects only the next reload; the current count is unaffected.
- done is sticky. If a W1C of done and an expiry occur in the same cycle, the expiry wins and done stays 1.
- A done clear in DONE leaves the state in DONE with busy=0.
- CLEAR has priority over everything:
  - State returns to IDLE and all registers, including LOAD/PRESCALE/INTR_EN/CTRL, are zeroed.
  - This applies mid-RUN as well, and interrupt drops on the next edge.
- interrupt is combinational from registered done and intr_en, so it is glitch-free relative to clk.
- Arithmetic is unsigned. The count never underflows because the decrement only occurs when count>=1.

Decomposition:
- Shared package bus_timer_pkg holds:
  - Register offset constants (OFF_START..OFF_CTRL).
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - STATUS bit positions.
- Sub-module timer_prescaler (PRE_W): inputs load, en, reload value; output tick when pre==0.
- The register file, FSM and read mux stay in the top module.

Test Plan:
- Reset, then read all 8 offsets -> every read returns 0 and interrupt=0.
- Write LOAD=3, PRESCALE=0, INTR_EN=1, START=1 at E0 -> COUNT reads 3,2,1 after E0,E1,E2; done=1, COUNT=0 and interrupt=1 after E3; STATUS reads 0x1.
- Write LOAD=2, PRESCALE=4, START -> interrupt rises exactly 10 cycles after the START edge. A W1C to STATUS bit0 then drops interrupt on the next edge.
- Write LOAD=0, START -> done=1 one edge later and the FSM is in DONE. Separately, with INTR_EN=0 and LOAD=5 expiring -> STATUS bit0=1 while interrupt stays 0.
- Auto-reload with LOAD=2, PRESCALE=0, CTRL=1:
  - done set at E2 and COUNT reloads to 2.
  - Writing LOAD=4 mid-RUN gives the next period of 4 cycles.
  - START issued during RUN is ignored.
- Mid-RUN, write CLEAR=1 with LOAD=100 -> next edge: STATUS=0, COUNT=0, LOAD reads 0, interrupt=0.
- Also assert reset mid-RUN -> identical result.
- W1C coincident with expiry -> done remains 1.
